// File: rtl/sti_pkg.sv
// Shared types for the STI word feeder: length encodings,
// burst-length helper and the feeder state enum.
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'd0;
  localparam logic [1:0] LEN_16 = 2'd1;
  localparam logic [1:0] LEN_24 = 2'd2;
  localparam logic [1:0] LEN_32 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SHIFT,
    GAP,
    FIN
  } feed_state_t;

  function automatic logic [5:0] bits_of_len(
    input logic [1:0] len
  );
    logic [2:0] bytes;
    bytes = {1'b0, len} + 3'd1;
    return {bytes, 3'b000};
  endfunction

endpackage

// File: rtl/sti_word_feeder.sv
// Sequences command words into the STI serializer and tracks bursts.
// Optional burst-length checking: define STI_FEEDER_CHECK_EN.
module sti_word_feeder #(
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  input  logic [1:0]  cmd_length,
  input  logic        cmd_fill,
  input  logic        cmd_msb,
  input  logic        cmd_low,
  input  logic        cmd_last,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  input  logic        oem_finish,
  output logic        frame_done,
  output logic        err_timeout,
  output logic        err_len
);
  import sti_pkg::*;

  feed_state_t state, state_n;

  logic [7:0] tmo_cnt;
  logic [5:0] bit_cnt;
  logic [2:0] gap_cnt;
  logic       accept;
  logic       tmo_hit;
  logic       gap_last;

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  // Fires on the last permitted WAIT cycle without so_valid.
  assign tmo_hit  = (state == WAIT) && !so_valid &&
                    ((tmo_cnt + 8'd1) == 8'(TIMEOUT));
  assign gap_last = (gap_cnt == 3'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (accept) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (so_valid)     state_n = SHIFT;
        else if (tmo_hit) state_n = IDLE;
      end
      SHIFT: begin
        if (!so_valid) begin
          if (pi_end)               state_n = FIN;
          else if (GAP_CYCLES == 0) state_n = IDLE;
          else                      state_n = GAP;
        end
      end
      GAP:   if (gap_last)   state_n = IDLE;
      FIN:   if (oem_finish) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load        <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      pi_data     <= '0;
      pi_length   <= '0;
      pi_fill     <= 1'b0;
      pi_msb      <= 1'b0;
      pi_low      <= 1'b0;
      pi_end      <= 1'b0;
      tmo_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      load       <= (state_n == ISSUE);
      frame_done <= (state == FIN) && oem_finish;
      if (accept) begin
        pi_data   <= cmd_data;
        pi_length <= cmd_length;
        pi_fill   <= cmd_fill;
        pi_msb    <= cmd_msb;
        pi_low    <= cmd_low;
        pi_end    <= cmd_last;
      end
      if (state == ISSUE)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 8'd1;
      if (state == WAIT && so_valid)
        bit_cnt <= 6'd1;
      else if (state == SHIFT && so_valid &&
               bit_cnt != 6'd63)
        bit_cnt <= bit_cnt + 6'd1;
      if (state == GAP) gap_cnt <= gap_cnt + 3'd1;
      else              gap_cnt <= '0;
      if (tmo_hit) err_timeout <= 1'b1;
    end
  end

`ifdef STI_FEEDER_CHECK_EN
  logic len_bad;
  logic stray;

  // so_valid only belongs to WAIT/SHIFT; anywhere else it is stray.
  assign stray   = so_valid && (state != WAIT) &&
                   (state != SHIFT);
  assign len_bad = stray ||
                   ((state == SHIFT) && !so_valid &&
                    (bit_cnt != bits_of_len(pi_length)));

  always_ff @(posedge clk) begin
    if (reset)        err_len <= 1'b0;
    else if (len_bad) err_len <= 1'b1;
  end
`else
  assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_sti_word_feeder.sv
// Directed self-checking bench for sti_word_feeder with a
// behavioural serializer that answers each load with so_valid.
module tb_sti_word_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_length;
  logic        cmd_fill;
  logic        cmd_msb;
  logic        cmd_low;
  logic        cmd_last;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill;
  logic        pi_msb;
  logic        pi_low;
  logic        pi_end;
  logic        so_valid;
  logic        oem_finish;
  logic        frame_done;
  logic        err_timeout;
  logic        err_len;

  int checks = 0;
  int fails  = 0;
  int ser_bits = 0;
  int n_load = 0;
  int n_done = 0;
  int cyc = 0;

`ifdef STI_FEEDER_CHECK_EN
  localparam logic EXP_LEN_ERR = 1'b1;
`else
  localparam logic EXP_LEN_ERR = 1'b0;
`endif

  sti_word_feeder #(
    .GAP_CYCLES(1),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data(cmd_data),
    .cmd_length(cmd_length),
    .cmd_fill(cmd_fill),
    .cmd_msb(cmd_msb),
    .cmd_low(cmd_low),
    .cmd_last(cmd_last),
    .load(load),
    .pi_data(pi_data),
    .pi_length(pi_length),
    .pi_fill(pi_fill),
    .pi_msb(pi_msb),
    .pi_low(pi_low),
    .pi_end(pi_end),
    .so_valid(so_valid),
    .oem_finish(oem_finish),
    .frame_done(frame_done),
    .err_timeout(err_timeout),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  // Serializer: so_valid starts two edges after load and lasts
  // ser_bits cycles; a reset aborts the burst.
  initial begin
    so_valid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (load && !reset && ser_bits > 0) begin
        int n;
        n = ser_bits;
        @(posedge clk);
        @(posedge clk);
        #2;
        so_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          #2;
          if (reset) break;
        end
        so_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (load) n_load++;
    if (frame_done) n_done++;
  endtask

  task automatic drive(
    input logic [15:0] d,
    input logic [1:0]  len,
    input logic        fill,
    input logic        msb,
    input logic        low,
    input logic        last
  );
    cmd_valid  = 1'b1;
    cmd_data   = d;
    cmd_length = len;
    cmd_fill   = fill;
    cmd_msb    = msb;
    cmd_low    = low;
    cmd_last   = last;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready got %b want 0", cmd_ready);
    end
    checks++;
    if ({load, frame_done, err_timeout, err_len} !== 4'b0) begin
      fails++;
      $display("FAIL reset_outs got %b want 0000",
               {load, frame_done, err_timeout, err_len});
    end
    checks++;
    if ({pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end}
        !== 22'd0) begin
      fails++;
      $display("FAIL reset_pi got %h want 0", pi_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_single();
    ser_bits = 8;
    n_load = 0;
    n_done = 0;
    drive(16'hA55A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (load !== 1'b1 || pi_data !== 16'hA55A) begin
      fails++;
      $display("FAIL single_load got load=%b data=%h want 1 a55a",
               load, pi_data);
    end
    checks++;
    if ({pi_length, pi_fill, pi_msb, pi_low, pi_end}
        !== 6'b00_0111) begin
      fails++;
      $display("FAIL single_ctrl got %b want 000111",
               {pi_length, pi_fill, pi_msb, pi_low, pi_end});
    end
    repeat (11) tick();
    checks++;
    if (cmd_ready !== 1'b0 || n_load != 1 || n_done != 0) begin
      fails++;
      $display("FAIL single_fin got rdy=%b loads=%0d done=%0d want 0 1 0",
               cmd_ready, n_load, n_done);
    end
    oem_finish = 1'b1;
    tick();
    oem_finish = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_done got done=%b rdy=%b want 1 1",
               frame_done, cmd_ready);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || n_done != 1) begin
      fails++;
      $display("FAIL single_once got done=%b cnt=%0d want 0 1",
               frame_done, n_done);
    end
    checks++;
    if (err_timeout !== 1'b0 || err_len !== 1'b0) begin
      fails++;
      $display("FAIL single_err got %b%b want 00",
               err_timeout, err_len);
    end
  endtask

  task automatic test_multi_word();
    logic [1:0] lens [4];
    logic [15:0] d;
    int cnt;
    bit moved;
    lens = '{2'd1, 2'd2, 2'd3, 2'd0};
    n_load = 0;
    n_done = 0;
    oem_finish = 1'b1;
    for (int w = 0; w < 4; w++) begin
      ser_bits = 8 * (int'(lens[w]) + 1);
      d = 16'h1000 + 16'(w * 16'h0111);
      drive(d, lens[w], w[0], w[1], ~w[0], w == 3);
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (load !== 1'b1 || pi_data !== d ||
          pi_length !== lens[w] || pi_end !== (w == 3)) begin
        fails++;
        $display("FAIL multi_load%0d got l=%b d=%h len=%0d e=%b want 1 %h %0d %b",
                 w, load, pi_data, pi_length, pi_end, d, lens[w], w == 3);
      end
      cnt = 0;
      moved = 1'b0;
      for (int i = 0; i < 80; i++) begin
        tick();
        cnt++;
        if (cmd_ready) break;
        if (pi_data !== d || pi_length !== lens[w]) moved = 1'b1;
      end
      checks++;
      if (cnt != ser_bits + 4 || moved) begin
        fails++;
        $display("FAIL multi_busy%0d got %0d held=%b want %0d 1",
                 w, cnt, !moved, ser_bits + 4);
      end
      checks++;
      if (frame_done !== (w == 3)) begin
        fails++;
        $display("FAIL multi_done%0d got %b want %b",
                 w, frame_done, w == 3);
      end
    end
    oem_finish = 1'b0;
    tick();
    checks++;
    if (n_load != 4 || n_done != 1) begin
      fails++;
      $display("FAIL multi_counts got %0d %0d want 4 1",
               n_load, n_done);
    end
  endtask

  task automatic test_timeout();
    bit early;
    ser_bits = 0;
    drive(16'h0F0F, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (err_timeout || cmd_ready) early = 1'b1;
    end
    checks++;
    if (early) begin
      fails++;
      $display("FAIL tmo_early got early=1 want 0");
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL tmo_fire got err=%b rdy=%b want 1 1",
               err_timeout, cmd_ready);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL tmo_sticky got %b want 1", err_timeout);
    end
    pulse_reset();
    checks++;
    if (err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL tmo_clear got %b want 0", err_timeout);
    end
  endtask

  task automatic test_len_check();
    int cnt;
    ser_bits = 15;
    drive(16'h1234, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      cnt++;
      if (cmd_ready) break;
    end
    checks++;
    if (cnt != 19) begin
      fails++;
      $display("FAIL len_busy got %0d want 19", cnt);
    end
    checks++;
    if (err_len !== EXP_LEN_ERR || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL len_err got len=%b tmo=%b want %b 0",
               err_len, err_timeout, EXP_LEN_ERR);
    end
    pulse_reset();
    checks++;
    if (err_len !== 1'b0) begin
      fails++;
      $display("FAIL len_clear got %b want 0", err_len);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    ser_bits = 32;
    drive(16'hBEEF, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    checks++;
    if (cmd_ready !== 1'b0 || so_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy got rdy=%b sv=%b want 0 1",
               cmd_ready, so_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({load, frame_done, err_timeout, err_len, cmd_ready,
         pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end}
        !== 27'd0) begin
      fails++;
      $display("FAIL mid_reset got load=%b data=%h rdy=%b want 0 0 0",
               load, pi_data, cmd_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || load !== 1'b0) begin
      fails++;
      $display("FAIL mid_idle got rdy=%b load=%b want 1 0",
               cmd_ready, load);
    end
    ser_bits = 8;
    drive(16'h00C3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (load !== 1'b1 || pi_data !== 16'h00C3) begin
      fails++;
      $display("FAIL mid_accept got load=%b data=%h want 1 00c3",
               load, pi_data);
    end
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      cnt++;
      if (cmd_ready) break;
    end
    checks++;
    if (cnt != 12 || err_len !== 1'b0) begin
      fails++;
      $display("FAIL mid_after got %0d len=%b want 12 0",
               cnt, err_len);
    end
  endtask

  task automatic test_back_to_back();
    int t_load [3];
    int t_done;
    int k;
    ser_bits = 16;
    n_load = 0;
    n_done = 0;
    t_done = -1;
    k = 0;
    oem_finish = 1'b1;
    drive(16'h0001, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (load && k < 3) begin
        t_load[k] = cyc;
        k++;
        cmd_data = 16'(k + 1);
        cmd_last = (k == 2);
      end
      if (frame_done) begin
        t_done = cyc;
        cmd_valid = 1'b0;
        break;
      end
    end
    oem_finish = 1'b0;
    repeat (5) tick();
    checks++;
    if (n_load != 3 || k != 3) begin
      fails++;
      $display("FAIL b2b_loads got %0d want 3", n_load);
    end
    checks++;
    if (k == 3 && (t_load[1] - t_load[0] != 21 ||
                   t_load[2] - t_load[1] != 21)) begin
      fails++;
      $display("FAIL b2b_spacing got %0d %0d want 21 21",
               t_load[1] - t_load[0], t_load[2] - t_load[1]);
    end
    checks++;
    if (k != 3 || t_done - t_load[2] != 20 || n_done != 1) begin
      fails++;
      $display("FAIL b2b_done got dt=%0d n=%0d want 20 1",
               (k == 3) ? t_done - t_load[2] : -1, n_done);
    end
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    cmd_length = '0;
    cmd_fill   = 1'b0;
    cmd_msb    = 1'b0;
    cmd_low    = 1'b0;
    cmd_last   = 1'b0;
    oem_finish = 1'b0;
    test_reset();
    test_single();
    test_multi_word();
    test_timeout();
    test_len_check();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
